// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the MIPS multicycle control path.
// ILLEGAL_TRAP_EN adds the TRAP state used for unknown opcodes.
package mips_ctrl_pkg;

  localparam int STATE_W = 4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_R_WB,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_BRANCH,
    S_ADDI_EX
`ifdef ILLEGAL_TRAP_EN
    ,
    S_TRAP
`endif
  } state_t;

  // Exactly one field is set for any opcode.
  typedef struct packed {
    logic rtype;
    logic lw;
    logic sw;
    logic beq;
    logic addi;
    logic illegal;
  } op_class_t;

endpackage

// File: rtl/mips_opcode_class.sv
// Opcode classifier: maps IR[31:26] to a one-hot instruction class.
// Purely combinational; anything unrecognised is flagged illegal.
module mips_opcode_class
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output op_class_t  cls
);

  // One-hot class decode, illegal when no known opcode matches.
  always_comb begin
    cls = '0;
    unique case (opcode)
      OP_RTYPE: cls.rtype   = 1'b1;
      OP_LW:    cls.lw      = 1'b1;
      OP_SW:    cls.sw      = 1'b1;
      OP_BEQ:   cls.beq     = 1'b1;
      OP_ADDI:  cls.addi    = 1'b1;
      default:  cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle main control FSM: FETCH/DECODE/EX/MEM/WB sequencing.
// ILLEGAL_TRAP_EN: unknown opcodes trap (illegal_op) instead of NOP.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic [1:0] alu_op,
  output logic       reg_dst,
  output logic       alu_src,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       branch
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic       illegal_op
`endif
);

  state_t    state;
  state_t    state_nxt;
  op_class_t cls;
  logic      hold_lw;
  logic      hold_addi;

  mips_opcode_class u_class (
    .opcode (opcode),
    .cls    (cls)
  );

  // State register; reset aborts any instruction straight to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Instruction class held from DECODE for MEM_ADDR and R_WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_lw   <= 1'b0;
      hold_addi <= 1'b0;
    end else if (state == S_DECODE) begin
      hold_lw   <= cls.lw;
      hold_addi <= cls.addi;
    end
  end

  // Next-state and Moore output decode (pc_write gated by fetch done).
  always_comb begin
    state_nxt  = state;
    alu_op     = ALUOP_ADD;
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    illegal_op = 1'b0;
`endif
    unique case (state)
      S_IDLE: begin
        if (en) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        mem_read = 1'b1;
        ir_write = 1'b1;
        alu_op   = ALUOP_ADD;
        if (mem_ready) begin
          pc_write  = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        unique case (1'b1)
          cls.rtype:        state_nxt = S_EXEC;
          cls.lw, cls.sw:   state_nxt = S_MEM_ADDR;
          cls.beq:          state_nxt = S_BRANCH;
          cls.addi:         state_nxt = S_ADDI_EX;
`ifdef ILLEGAL_TRAP_EN
          default:          state_nxt = S_TRAP;
`else
          default:          state_nxt = S_FETCH;
`endif
        endcase
      end
      S_EXEC: begin
        alu_op    = ALUOP_FUNCT;
        alu_src   = 1'b0;
        state_nxt = S_R_WB;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = ~hold_addi;
        mem_to_reg = 1'b0;
        state_nxt  = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_op    = ALUOP_ADD;
        alu_src   = 1'b1;
        state_nxt = hold_lw ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        if (mem_ready) state_nxt = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        reg_dst    = 1'b0;
        state_nxt  = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        if (mem_ready) state_nxt = S_FETCH;
      end
      S_BRANCH: begin
        alu_op    = ALUOP_SUB;
        alu_src   = 1'b0;
        branch    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_ADDI_EX: begin
        alu_op    = ALUOP_ADD;
        alu_src   = 1'b1;
        state_nxt = S_R_WB;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP: begin
        illegal_op = 1'b1;
      end
`endif
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
